// File: rtl/mb128_host.sv
// mb128_host: MB128 / Save-kun host initiator driving CLR/SEL and sampling the nibble.
// Optional: define MB128_HOST_IDENT_EN to abort a command when the ident bit is absent.
module mb128_host #(
  parameter int HALF_DIV = 8
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [9:0]  cmd_addr,
  input  logic [19:0] cmd_len,
  input  logic        wr_bit,
  input  logic        wr_valid,
  output logic        wr_ready,
  output logic        rd_bit,
  output logic        rd_valid,
  output logic        done,
  output logic        ident_ok,
  output logic        busy,
  output logic        o_Clr,
  output logic        o_Sel,
  input  logic [3:0]  i_Data
);

  localparam int HW = $clog2(HALF_DIV);
  localparam logic [HW-1:0] H_LAST = HW'(HALF_DIV - 1);
  localparam logic [7:0] SYNC_BYTE = 8'hA8;

  typedef enum logic [3:0] {
    S_IDLE, S_SYNC, S_ID1, S_ID2, S_REQ,
    S_ADDR, S_LEN, S_DATA, S_TRAIL
  } state_t;

  state_t state, state_n;

  logic [HW-1:0] hcnt;
  logic          phase;
  logic [19:0]   scnt;
  logic          wgot;
  logic          wbit;
  logic          wr_q;
  logic [9:0]    addr_q;
  logic [19:0]   len_q;

  logic accept;
  logic slot_end;
  logic wr_slot;
  logic stall;
  logic unused_nibble;

  assign unused_nibble = ^{i_Data[3], i_Data[1]};

  assign accept   = cmd_valid & (state == S_IDLE);
  assign slot_end = (state != S_IDLE) & phase & (hcnt == H_LAST);
  assign wr_slot  = (state == S_DATA) & wr_q & ~phase
                  & (hcnt == '0) & ~wgot;
  assign stall    = wr_slot & ~wr_valid;

  // State register
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_n;
  end

  // Next state: advance when the last slot of a field ends
  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:  if (cmd_valid) state_n = S_SYNC;
      S_SYNC:  if (slot_end && scnt == 20'd7) state_n = S_ID1;
      S_ID1:   if (slot_end) state_n = S_ID2;
      S_ID2:   if (slot_end) begin
`ifdef MB128_HOST_IDENT_EN
        state_n = i_Data[2] ? S_REQ : S_IDLE;
`else
        state_n = S_REQ;
`endif
      end
      S_REQ:   if (slot_end) state_n = S_ADDR;
      S_ADDR:  if (slot_end && scnt == 20'd9) state_n = S_LEN;
      S_LEN:   if (slot_end && scnt == 20'd19)
        state_n = (len_q == 20'd0) ? S_TRAIL : S_DATA;
      S_DATA:  if (slot_end && scnt == len_q - 20'd1)
        state_n = S_TRAIL;
      S_TRAIL: if (slot_end && scnt == (wr_q ? 20'd4 : 20'd2))
        state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Outputs: pin levels and handshake decoded from state and counters
  always_comb begin
    busy      = (state != S_IDLE);
    cmd_ready = ~busy;
    o_Clr     = busy & phase;
    wr_ready  = wr_slot & wr_valid;
    o_Sel     = 1'b0;
    unique case (state)
      S_SYNC:  o_Sel = SYNC_BYTE[scnt[2:0]];
      S_ID2:   o_Sel = 1'b1;
      S_REQ:   o_Sel = ~wr_q;
      S_ADDR:  o_Sel = addr_q[scnt[3:0]];
      S_LEN:   o_Sel = len_q[scnt[4:0]];
      S_DATA:  o_Sel = wr_q & (wgot ? wbit : (wr_valid & wr_bit));
      default: o_Sel = 1'b0;
    endcase
  end

  // Slot timing: half-period counter, phase, slot index within a field
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      hcnt  <= '0;
      phase <= 1'b0;
      scnt  <= '0;
      wgot  <= 1'b0;
    end else if (state == S_IDLE) begin
      hcnt  <= '0;
      phase <= 1'b0;
      scnt  <= '0;
      wgot  <= 1'b0;
    end else if (stall) begin
      hcnt  <= hcnt;
    end else if (slot_end) begin
      hcnt  <= '0;
      phase <= 1'b0;
      wgot  <= 1'b0;
      scnt  <= (state_n == state) ? scnt + 20'd1 : 20'd0;
    end else begin
      wgot  <= wgot | wr_ready;
      if (hcnt == H_LAST) begin
        hcnt  <= '0;
        phase <= 1'b1;
      end else begin
        hcnt  <= hcnt + 1'b1;
      end
    end
  end

  // Command fields and the write bit held for the current slot
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      wr_q   <= 1'b0;
      addr_q <= '0;
      len_q  <= '0;
      wbit   <= 1'b0;
    end else begin
      if (accept) begin
        wr_q   <= cmd_write;
        addr_q <= cmd_addr;
        len_q  <= cmd_len;
      end
      if (wr_ready) wbit <= wr_bit;
    end
  end

  // Registered status: read strobe, ident result, end-of-command pulse
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      rd_bit   <= 1'b0;
      rd_valid <= 1'b0;
      ident_ok <= 1'b0;
      done     <= 1'b0;
    end else begin
      done     <= slot_end & (state_n == S_IDLE);
      rd_valid <= slot_end & (state == S_DATA) & ~wr_q;
      if (slot_end && state == S_DATA && !wr_q)
        rd_bit <= i_Data[0];
      if (accept)
        ident_ok <= 1'b0;
      else if (slot_end && state == S_ID2)
        ident_ok <= i_Data[2];
    end
  end

endmodule

// File: tb/tb_mb128_host.sv
// tb_mb128_host: directed bench for mb128_host with a bit-level MB128 device
// model, a memory model and a per-cycle compare process.
module tb_mb128_host;

  localparam int HD = 2;

  logic        clk_sys = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_write = 1'b0;
  logic [9:0]  cmd_addr = '0;
  logic [19:0] cmd_len = '0;
  logic        wr_bit = 1'b0;
  logic        wr_valid = 1'b0;
  logic [3:0]  i_Data = 4'h0;
  logic        cmd_ready, wr_ready, rd_bit, rd_valid;
  logic        done, ident_ok, busy, o_Clr, o_Sel;

  int errors = 0;
  int checks = 0;

  bit present = 1'b1;
  bit rom [int];
  bit mem [int];
  bit rx [$];
  bit exp_rd [$];
  bit wq [$];
  int rx_base = 0;
  int rd_base = 0;
  int edges = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  bit exp_ident = 1'b0;

  int dk;
  bit dev_req;
  int dev_addr;
  int dev_len;

  always #5 clk_sys = ~clk_sys;

  mb128_host #(.HALF_DIV(HD)) dut (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_write(cmd_write),
    .cmd_addr (cmd_addr),
    .cmd_len  (cmd_len),
    .wr_bit   (wr_bit),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .rd_bit   (rd_bit),
    .rd_valid (rd_valid),
    .done     (done),
    .ident_ok (ident_ok),
    .busy     (busy),
    .o_Clr    (o_Clr),
    .o_Sel    (o_Sel),
    .i_Data   (i_Data)
  );

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic bit model_bit(input int a);
    if (mem.exists(a)) return mem[a];
    if (rom.exists(a)) return rom[a];
    return 1'b0;
  endfunction

  // Device model: one protocol bit per CLR rising edge
  always @(posedge o_Clr) begin
    rx.push_back(o_Sel);
    edges++;
    dk = rx.size() - 1 - rx_base;
    i_Data = 4'h0;
    if (dk == 0) begin
      dev_req = 1'b0;
      dev_len = 0;
    end
    if (dk == 40) begin
      dev_req = rx[rx_base + 10];
      dev_addr = 0;
      dev_len = 0;
      for (int i = 0; i < 10; i++)
        dev_addr |= int'(rx[rx_base + 11 + i]) << i;
      for (int i = 0; i < 20; i++)
        dev_len |= int'(rx[rx_base + 21 + i]) << i;
    end
    if (present) begin
      if (dk == 9) i_Data[2] = 1'b1;
      if (dk >= 41 && dk < 41 + dev_len) begin
        if (dev_req) i_Data[0] = model_bit(dev_addr * 1024 + dk - 41);
        else mem[dev_addr * 1024 + dk - 41] = o_Sel;
      end
    end
  end

  // Per-cycle compare against the model
  always @(negedge clk_sys) begin
    if (reset_n) begin
      checks++;
      if (cmd_ready !== !busy || (!busy && (o_Clr || o_Sel))) begin
        errors++;
        $display("FAIL idle_pins: busy=%b ready=%b clr=%b sel=%b",
                 busy, cmd_ready, o_Clr, o_Sel);
      end
      if (rd_valid) begin
        check("rd_in_range", (rd_cnt - rd_base) < exp_rd.size(), 1);
        if ((rd_cnt - rd_base) < exp_rd.size())
          check("rd_bit", rd_bit, exp_rd[rd_cnt - rd_base]);
        rd_cnt++;
      end
      if (wr_ready) wr_cnt++;
      if (done) begin
        done_cnt++;
        check("ident_ok", ident_ok, exp_ident);
      end
    end
  end

  task automatic run_cmd(input string nm, input bit wr,
                         input logic [9:0] a, input logic [19:0] l,
                         input int exp_edges, input int stall_at);
    int eb, wb, db, widx, hold, budget, win_eb, win_edges, stall_hi, mism;
    bit consumed, seen, abort;
    bit exp_bits [$];
    logic [7:0] sb;
    sb = 8'hA8;
    eb = edges;
    wb = wr_cnt;
    db = done_cnt;
    rx_base = rx.size();
    rd_base = rd_cnt;
    abort = 1'b0;
`ifdef MB128_HOST_IDENT_EN
    abort = !present;
`endif
    exp_ident = present;
    exp_rd.delete();
    if (!wr && !abort)
      for (int i = 0; i < int'(l); i++)
        exp_rd.push_back(present ? model_bit(int'(a) * 1024 + i) : 1'b0);
    for (int i = 0; i < 8; i++) exp_bits.push_back(sb[i]);
    exp_bits.push_back(1'b0);
    exp_bits.push_back(1'b1);
    if (!abort) begin
      exp_bits.push_back(!wr);
      for (int i = 0; i < 10; i++) exp_bits.push_back(a[i]);
      for (int i = 0; i < 20; i++) exp_bits.push_back(l[i]);
      for (int i = 0; i < int'(l); i++)
        exp_bits.push_back(wr ? wq[i] : 1'b0);
      for (int i = 0; i < (wr ? 5 : 3); i++) exp_bits.push_back(1'b0);
    end
    @(posedge clk_sys); #1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_len   = l;
    cmd_valid = 1'b1;
    @(negedge clk_sys);
    check({nm, "_ready"}, cmd_ready, 1);
    @(posedge clk_sys); #1;
    cmd_valid = 1'b0;
    widx = 0;
    hold = 0;
    win_eb = 0;
    win_edges = 0;
    stall_hi = 0;
    seen = 1'b0;
    wr_valid = wr && wq.size() > 0;
    wr_bit = wr && wq.size() > 0 ? wq[0] : 1'b0;
    budget = 4 * (60 + int'(l)) + 200;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk_sys);
      consumed = wr_ready;
      if (hold == 14) win_eb = edges;
      if (hold >= 1 && hold <= 14) stall_hi += int'(o_Clr);
      if (hold == 1) win_edges = edges - win_eb;
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(posedge clk_sys); #1;
      if (consumed) begin
        widx++;
        if (widx == stall_at) hold = 20;
      end
      if (hold > 0) begin
        wr_valid = 1'b0;
        hold--;
      end else if (wr && widx < wq.size()) begin
        wr_valid = 1'b1;
        wr_bit = wq[widx];
      end else begin
        wr_valid = 1'b0;
        wr_bit = 1'b0;
      end
    end
    check({nm, "_done_seen"}, seen, 1);
    wr_valid = 1'b0;
    wr_bit = 1'b0;
    repeat (4) @(negedge clk_sys);
    check({nm, "_edges"}, edges - eb, exp_edges);
    check({nm, "_stream_len"}, rx.size() - rx_base, exp_bits.size());
    mism = 0;
    for (int i = 0; i < exp_bits.size() && rx_base + i < rx.size(); i++)
      if (rx[rx_base + i] != exp_bits[i]) mism++;
    check({nm, "_stream_bits"}, mism, 0);
    check({nm, "_done_cnt"}, done_cnt - db, 1);
    check({nm, "_rd_cnt"}, rd_cnt - rd_base, exp_rd.size());
    check({nm, "_wr_cnt"}, wr_cnt - wb, (wr && !abort) ? int'(l) : 0);
    if (stall_at > 0) begin
      check({nm, "_stall_edges"}, win_edges, 0);
      check({nm, "_stall_clr"}, stall_hi, 0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int eb, db, c27;
    bit [7:0] pat;
    pat = 8'b0100_1101;
    for (int i = 0; i < 8; i++) rom[3 * 1024 + i] = pat[i];

    @(negedge clk_sys);
    check("reset_outs",
          {cmd_ready, busy, o_Clr, o_Sel, done, rd_valid, wr_ready,
           ident_ok, rd_bit}, 9'b1_0000_0000);
    @(negedge clk_sys);
    reset_n = 1'b1;
    repeat (2) @(negedge clk_sys);

    run_cmd("rd8", 1'b0, 10'd3, 20'd8, 52, 0);

    wq = '{1'b1, 1'b1, 1'b0, 1'b1};
    run_cmd("wr4", 1'b1, 10'h3FF, 20'd4, 50, 0);
    check("mem_3ff_0", model_bit(32'h3FF * 1024 + 0), 1);
    check("mem_3ff_1", model_bit(32'h3FF * 1024 + 1), 1);
    check("mem_3ff_2", model_bit(32'h3FF * 1024 + 2), 0);
    check("mem_3ff_3", model_bit(32'h3FF * 1024 + 3), 1);
    wq.delete();
    run_cmd("rdback", 1'b0, 10'h3FF, 20'd4, 48, 0);

    run_cmd("rd0", 1'b0, 10'd12, 20'd0, 44, 0);
    run_cmd("wr0", 1'b1, 10'd12, 20'd0, 46, 0);

    wq = '{1'b1, 1'b0, 1'b1};
    run_cmd("wrstall", 1'b1, 10'd7, 20'd3, 49, 2);
    check("mem_7_0", model_bit(7 * 1024 + 0), 1);
    check("mem_7_1", model_bit(7 * 1024 + 1), 0);
    check("mem_7_2", model_bit(7 * 1024 + 2), 1);
    wq.delete();

    present = 1'b0;
`ifdef MB128_HOST_IDENT_EN
    run_cmd("absent", 1'b0, 10'd1, 20'd2, 10, 0);
`else
    run_cmd("absent", 1'b0, 10'd1, 20'd2, 46, 0);
`endif
    present = 1'b1;

    eb = edges;
    db = done_cnt;
    rx_base = rx.size();
    exp_rd.delete();
    @(posedge clk_sys); #1;
    cmd_write = 1'b0;
    cmd_addr  = 10'd5;
    cmd_len   = 20'd40;
    cmd_valid = 1'b1;
    @(posedge clk_sys); #1;
    cmd_valid = 1'b0;
    c27 = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk_sys);
      if (edges - eb >= 27) begin
        c27 = edges - eb;
        break;
      end
    end
    check("len5_reached", c27, 27);
    check("len5_sel", {o_Clr, o_Sel, busy}, 3'b111);
    #1 reset_n = 1'b0;
    #1;
    check("rst_async", {o_Clr, o_Sel, busy, cmd_ready, done}, 5'b00010);
    repeat (3) @(negedge clk_sys);
    reset_n = 1'b1;
    @(negedge clk_sys);
    check("rst_no_done", done_cnt - db, 0);
    check("rst_ready", cmd_ready, 1);
    run_cmd("after_rst", 1'b0, 10'd2, 20'd0, 44, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mb128_host.md
Name: mb128_host

Overview:
- Host-side initiator for the Memory Base 128 / Save-kun serial protocol. It generates the CLR (clock) and SEL (data) joypad lines and samples the 4-bit joypad return nibble.
- Executes one read or write transaction per accepted command: sync byte, ident, request, address, length, data bits, trailing clocks.
- Used by the bench/loopback path and by a future host-side save tool that talks to the MB128 device model over the joypad pins.

Parameters:
- HALF_DIV, 8, clk_sys cycles per half bit-period. Legal minimum is 2.

Ports:
- clk_sys  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  10  address in 128-byte units
- cmd_len  in  20  transfer length in bits
- wr_bit  in  1  write data bit
- wr_valid  in  1  wr_bit is valid
- wr_ready  out  1  one-cycle pulse when wr_bit is consumed
- rd_bit  out  1  read data bit
- rd_valid  out  1  one-cycle strobe for rd_bit
- done  out  1  one-cycle pulse at end of transaction
- ident_ok  out  1  registered result of the ident check
- busy  out  1  high whenever state is not IDLE
- o_Clr  out  1  protocol clock to device; device acts on rising edge
- o_Sel  out  1  protocol data to device
- i_Data  in  4  device return nibble

Behaviour:
- Reset is asynchronous on reset_n low. State goes to IDLE. All outputs clear to 0 except cmd_ready, which is 1. Counters clear.
- Bit slot, 2*HALF_DIV cycles:
  - o_Sel is set at slot start and held for the whole slot.
  - o_Clr is 0 for HALF_DIV cycles, then 1 for HALF_DIV cycles.
  - i_Data is sampled on the last cycle of the high phase.
  - The next slot starts on the following cycle with o_Clr returning to 0.
- Command accept: cmd_valid & cmd_ready. Fields are latched; the first slot starts on the next cycle. Between transactions o_Clr=0 and o_Sel=0.
- States and the bits each sends:
  - SYNC: 8 slots, 0xA8 LSB first.
  - ID1: 1 slot, Sel=0.
  - ID2: 1 slot, Sel=1. ident_ok <= sampled i_Data[2].
  - REQ: 1 slot, Sel = ~cmd_write (1 = read).
  - ADDR: 10 slots, LSB first.
  - LEN: 20 slots, LSB first. If len==0, skip DATA.
  - DATA: len slots.
  - TRAIL: 3 slots for read, 5 slots for write, Sel=0.
  - IDLE.
- Read DATA: each slot drives Sel=0 and samples i_Data[0] into rd_bit. rd_valid pulses in the cycle after the sample. Bits arrive in ascending device bit-address order.
- Write DATA:
  - At slot start the host needs wr_valid=1. If wr_valid=0 it stalls in low phase with o_Clr=0; no rising edge is emitted, so the device is unaffected.
  - When wr_valid=1, the bit is latched into o_Sel, wr_ready pulses in that cycle, and the slot proceeds.
- done pulses one cycle after the final TRAIL slot ends. busy falls and cmd_ready rises on that same cycle.
- Total rising edges per transaction = 41 + len + (3 for read, 5 for write).
- Counters:
  - Slot counter is 20 bits, compared with ==. len = 0xFFFFF is legal and no counter wraps.
  - Half-period counter counts 0..HALF_DIV-1.
- Reset mid-transaction: o_Clr and o_Sel drop to 0 immediately and no done pulse is issued. The device may be left out of IDLE; resynchronising it is the caller's responsibility.
- cmd_valid while busy is ignored; no queueing.

Optional Feature:
- MB128_HOST_IDENT_EN
  - Defined: if the ID2 sample gives i_Data[2]=0, abort to IDLE after that slot and pulse done with ident_ok=0. No REQ/ADDR/LEN bits are sent.
  - Undefined: ident_ok is still reported, but the transaction always runs to completion.

Test Plan:
- Read, HALF_DIV=2, addr=3, len=8, device model preloaded bits 1,0,1,1,0,0,1,0 -> 52 o_Clr rising edges; 8 rd_valid pulses with bits 1,0,1,1,0,0,1,0; ident_ok=1; one done pulse.
- Write, addr=0x3FF, len=4, bits 1,1,0,1 -> 50 rising edges; device memory at 0x3FF*1024+0..3 reads back 1,1,0,1; 4 wr_ready pulses.
- Zero-length read and zero-length write -> 44 and 46 rising edges respectively; no rd_valid or wr_ready.
- Write len=3 with wr_valid held low 20 cycles before bit 2 -> o_Clr stays 0 for the whole stall; the device still stores all 3 bits correctly.
- Device absent (i_Data=0), MB128_HOST_IDENT_EN defined -> exactly 10 rising edges, done with ident_ok=0. With the macro undefined -> full 41+len+trail edges.
- reset_n low in LEN slot 5 of a read -> o_Clr, o_Sel, busy go to 0 asynchronously; no done; next command after reset is accepted with cmd_ready=1.
